instr_fetch_unit: RTL and testbench

Instruction-fetch stage of the 16-bit pipelined processor. It is the producer for the decoder: it owns the PC, drives the synchronous instruction memory, and presents {instr, pc, pc_1} with a valid flag.
- Handles pipeline stall (back-pressure from decode/hazard logic).
- Handles redirect (branch/jump from EX).
- Stops fetching on a HALT opcode.

---
 rtl/instr_fetch_unit_pkg.sv | 23 ++
 rtl/instr_fetch_unit_hold_buf.sv | 56 +++++
 rtl/instr_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_fetch_unit_pkg                                         |
// | Description : Shared widths, opcode field location and encodings for the   |
// |               instruction-fetch stage of the 16-bit pipelined processor.   |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package instr_fetch_unit_pkg;

  localparam int DEF_PC_W    = 8;
  localparam int DEF_INSTR_W = 16;

  // Opcode field location inside an instruction word.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0]       DEF_HALT_OPCODE = 4'hF;
  localparam logic [DEF_INSTR_W-1:0] NOP             = 16'h0000;

endpackage : instr_fetch_unit_pkg
`default_nettype wire

// File: rtl/instr_fetch_unit_hold_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_hold_buf                                               |
// | Description : One-entry skid buffer (data, pc, valid) that catches an      |
// |               instruction-memory response arriving while decode stalls.    |
// | Ports       : clk, rst          - clock, async active-high reset           |
// |               i_push/i_pop      - load entry / release entry               |
// |               i_clear           - discard entry (wins over push and pop)   |
// |               i_push_data/pc    - entry contents to load                   |
// |               o_valid/data/pc   - current entry                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_hold_buf
  import instr_fetch_unit_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_push_data,
  input  logic [PC_W-1:0]    i_push_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_data,
  output logic [PC_W-1:0]    o_pc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_data;
  logic [PC_W-1:0]    r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= INSTR_W'(NOP);
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_data  <= i_push_data;
      r_pc    <= i_push_pc;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_pc    = r_pc;

endmodule : fetch_hold_buf
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_fetch_unit                                             |
// | Description : Fetch stage. Owns the PC, drives the synchronous instruction |
// |               memory and presents {instr, pc, pc_1} with a valid flag to   |
// |               decode. Handles stall, redirect and HALT.                    |
// | Ports       : clk, rst            - clock, async active-high reset         |
// |               imem_addr/en/rdata  - instruction memory (1-cycle read)      |
// |               stall               - decode cannot accept, hold outputs     |
// |               redirect_valid/pc   - change-of-flow request from EX         |
// |               instr, pc, pc_1     - fetched instruction and its addresses  |
// |               if_valid, halted    - output valid, fetch stopped by HALT    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int               PC_W        = DEF_PC_W,
  parameter int               INSTR_W     = DEF_INSTR_W,
  parameter logic [PC_W-1:0]  RESET_PC    = '0,
  parameter logic [OPC_W-1:0] HALT_OPCODE = DEF_HALT_OPCODE
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_1,
  output logic               if_valid,
  output logic               halted
);

  logic [PC_W-1:0]    r_fetch_pc;
  logic               r_req_valid;   // a memory response for r_req_pc is on imem_rdata this cycle
  logic [PC_W-1:0]    r_req_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_pc_1;
  logic               r_if_valid;
  logic               r_halted;

  logic               w_redirect;
  logic               w_fire;
  logic               w_hb_valid;
  logic [INSTR_W-1:0] w_hb_data;
  logic [PC_W-1:0]    w_hb_pc;
  logic               w_cap_valid;
  logic [INSTR_W-1:0] w_cap_instr;
  logic [PC_W-1:0]    w_cap_pc;
  logic               w_cap_halt;

  // A redirect arriving after HALT is ignored; only reset leaves the halted state.
  assign w_redirect = redirect_valid && !r_halted;
  assign w_fire     = !stall && !r_halted && !redirect_valid;

  assign imem_addr = r_fetch_pc;
  assign imem_en   = w_fire;

  // The hold buffer is always older than any in-flight response, so it drains first.
  // Both cannot be valid together: the buffer only fills on a stall edge, which also
  // retires the in-flight request, and no fetch is issued while stalled.
  assign w_cap_valid = w_hb_valid || r_req_valid;
  assign w_cap_instr = w_hb_valid ? w_hb_data : imem_rdata;
  assign w_cap_pc    = w_hb_valid ? w_hb_pc   : r_req_pc;
  assign w_cap_halt  = w_cap_valid && (w_cap_instr[OPC_MSB:OPC_LSB] == HALT_OPCODE);

  fetch_hold_buf #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_hold_buf (
    .clk         (clk),
    .rst         (rst),
    .i_push      (!w_redirect && stall && r_req_valid),
    .i_pop       (!w_redirect && !stall),
    .i_clear     (w_redirect),
    .i_push_data (imem_rdata),
    .i_push_pc   (r_req_pc),
    .o_valid     (w_hb_valid),
    .o_data      (w_hb_data),
    .o_pc        (w_hb_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc  <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_pc    <= '0;
      r_instr     <= INSTR_W'(NOP);
      r_pc        <= '0;
      r_pc_1      <= '0;
      r_if_valid  <= 1'b0;
      r_halted    <= 1'b0;
    end else if (w_redirect) begin
      r_fetch_pc  <= redirect_pc;
      r_req_valid <= 1'b0;
      r_if_valid  <= 1'b0;
    end else if (stall) begin
      // Any response on the bus this cycle has been pushed into the hold buffer.
      r_req_valid <= 1'b0;
    end else begin
      if (w_fire) begin
        r_fetch_pc <= r_fetch_pc + 1'b1;
        r_req_pc   <= r_fetch_pc;
      end
      // A fetch issued on the edge that captures HALT is squashed.
      r_req_valid <= w_fire && !w_cap_halt;
      if (w_cap_valid) begin
        r_instr    <= w_cap_instr;
        r_pc       <= w_cap_pc;
        r_pc_1     <= w_cap_pc + 1'b1;
        r_if_valid <= 1'b1;
      end else begin
        r_if_valid <= 1'b0;
      end
      if (w_cap_halt) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign instr    = r_instr;
  assign pc       = r_pc;
  assign pc_1     = r_pc_1;
  assign if_valid = r_if_valid;
  assign halted   = r_halted;

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_fetch_unit                                          |
// | Description : Self-checking bench for instr_fetch_unit. A behavioural      |
// |               synchronous memory feeds two instances (RESET_PC 00 and FE). |
// |               Expected deliveries are queued as stimulus is applied and    |
// |               popped whenever decode accepts an output.                    |
// | Ports       : none                                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_instr_fetch_unit;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  pc;
    logic [7:0]  pc_1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;

  logic [7:0]  imem_addr;
  logic        imem_en;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [7:0]  pc;
  logic [7:0]  pc_1;
  logic        if_valid;
  logic        halted;

  logic [7:0]  w_imem_addr;
  logic        w_imem_en;
  logic [15:0] w_imem_rdata;
  logic [15:0] w_instr;
  logic [7:0]  w_pc;
  logic [7:0]  w_pc_1;
  logic        w_if_valid;
  logic        w_halted;
  logic        z_bit = 1'b0;
  logic [7:0]  z_pc  = 8'h00;

  logic [15:0] mem   [256];
  logic [15:0] mem_w [256];

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en)   imem_rdata   <= mem[imem_addr];
  always @(posedge clk) if (w_imem_en) w_imem_rdata <= mem_w[w_imem_addr];

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr          (instr),
    .pc             (pc),
    .pc_1           (pc_1),
    .if_valid       (if_valid),
    .halted         (halted)
  );

  instr_fetch_unit #(.RESET_PC(8'hFE)) dut_w (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (w_imem_addr),
    .imem_en        (w_imem_en),
    .imem_rdata     (w_imem_rdata),
    .stall          (z_bit),
    .redirect_valid (z_bit),
    .redirect_pc    (z_pc),
    .instr          (w_instr),
    .pc             (w_pc),
    .pc_1           (w_pc_1),
    .if_valid       (w_if_valid),
    .halted         (w_halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] a);
    exp_t e;
    e.instr = mem[a];
    e.pc    = a;
    e.pc_1  = a + 8'd1;
    sb.push_back(e);
  endtask

  task automatic wait_pc(input logic [7:0] t, input string tag);
    int n = 0;
    while (!(if_valid === 1'b1 && pc === t) && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(if_valid === 1'b1 && pc === t), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_instr"},    32'(instr),    32'h0);
    chk({tag, "_pc"},       32'(pc),       32'h0);
    chk({tag, "_pc_1"},     32'(pc_1),     32'h0);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'h0);
    chk({tag, "_halted"},   32'(halted),   32'h0);
  endtask

  // Decode accepts an output on an edge where if_valid=1, stall=0 and no flush.
  always @(negedge clk) begin
    if (rst === 1'b0 && if_valid === 1'b1 && stall === 1'b0 && redirect_valid === 1'b0) begin
      n_vec++;
      assert (sb.size() > 0) else begin
        n_err++;
        $error("FAIL sb_extra observed pc=%0h expected=none", pc);
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_instr", 32'(instr), 32'(e.instr));
        chk("sb_pc",    32'(pc),    32'(e.pc));
        chk("sb_pc_1",  32'(pc_1),  32'(e.pc_1));
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 16'h1000 + 16'(i);
      mem_w[i] = 16'h1000 + 16'(i);
    end
    rst            = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("rst0");
    chk("rst0_addr",   32'(imem_addr),   32'h00);
    chk("rst0_w_addr", 32'(w_imem_addr), 32'hFE);
    tick();
    tick();
    rst = 1'b0;

    // Normal flow, stall, then redirect
    for (int a = 0; a <= 16'h0F; a++) push_exp(8'(a));
    push_exp(8'h40);
    push_exp(8'h41);

    tick();
    chk("t1_lat1_valid", 32'(if_valid), 32'h0);
    tick();
    chk("t1_first_valid", 32'(if_valid), 32'h1);
    chk("t1_first_pc",    32'(pc),       32'h00);
    chk("t1_first_instr", 32'(instr),    32'h1000);
    chk("t1_first_pc_1",  32'(pc_1),     32'h01);
    chk("t2_pc_fe",   32'(w_pc),   32'hFE);
    chk("t2_pc_1_ff", 32'(w_pc_1), 32'hFF);
    tick();
    chk("t1_second_pc", 32'(pc), 32'h01);
    chk("t2_pc_ff",   32'(w_pc),   32'hFF);
    chk("t2_pc_1_00", 32'(w_pc_1), 32'h00);
    tick();
    chk("t2_pc_00",   32'(w_pc),    32'h00);
    chk("t2_pc_1_01", 32'(w_pc_1),  32'h01);
    chk("t2_instr",   32'(w_instr), 32'h1000);

    wait_pc(8'h05, "t3_reach_05");
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_hold_pc",    32'(pc),        32'h05);
      chk("t3_hold_valid", 32'(if_valid),  32'h1);
      chk("t3_hold_addr",  32'(imem_addr), 32'h07);
      chk("t3_hold_en",    32'(imem_en),   32'h0);
    end
    stall = 1'b0;
    tick();
    chk("t3_rel_pc06", 32'(pc), 32'h06);
    tick();
    chk("t3_rel_pc07", 32'(pc), 32'h07);

    wait_pc(8'h10, "t4_reach_10");
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    #1;
    chk("t4_en_during_redir", 32'(imem_en), 32'h0);
    tick();
    redirect_valid = 1'b0;
    chk("t4_flush_valid", 32'(if_valid),  32'h0);
    chk("t4_new_addr",    32'(imem_addr), 32'h40);
    tick();
    chk("t4_gap_valid", 32'(if_valid), 32'h0);
    tick();
    chk("t4_tgt_valid", 32'(if_valid), 32'h1);
    chk("t4_tgt_pc",    32'(pc),       32'h40);
    chk("t4_tgt_instr", 32'(instr),    32'h1040);
    tick();
    chk("t4_next_pc", 32'(pc), 32'h41);
    @(negedge clk);
    #1;
    chk("tA_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset mid-cycle
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst1");

    // HALT
    mem[3] = 16'hF000;
    tick();
    tick();
    rst = 1'b0;
    for (int a = 0; a < 4; a++) push_exp(8'(a));
    repeat (4) tick();
    chk("t5_pre_halted", 32'(halted), 32'h0);
    tick();
    chk("t5_halt_pc",     32'(pc),       32'h03);
    chk("t5_halt_instr",  32'(instr),    32'hF000);
    chk("t5_halt_valid",  32'(if_valid), 32'h1);
    chk("t5_halted",      32'(halted),   32'h1);
    chk("t5_halt_en",     32'(imem_en),  32'h0);
    stall = 1'b1;
    tick();
    chk("t5_stall_valid", 32'(if_valid), 32'h1);
    chk("t5_stall_pc",    32'(pc),       32'h03);
    stall = 1'b0;
    tick();
    chk("t5_acc_valid",  32'(if_valid), 32'h0);
    chk("t5_acc_halted", 32'(halted),   32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h20;
    #1;
    chk("t5_redir_en", 32'(imem_en), 32'h0);
    tick();
    tick();
    chk("t5_ign_valid",  32'(if_valid),  32'h0);
    chk("t5_ign_halted", 32'(halted),    32'h1);
    chk("t5_ign_en",     32'(imem_en),   32'h0);
    redirect_valid = 1'b0;
    chk("t5_drained", 32'(sb.size()), 32'd0);
    rst = 1'b1;
    #1;
    chk("t5_rst_halted", 32'(halted), 32'h0);

    // Redirect + stall together, then reset with the hold buffer full
    mem[3] = 16'h1003;
    tick();
    tick();
    rst = 1'b0;
    push_exp(8'h00);
    tick();
    tick();
    chk("t6_pc00", 32'(pc), 32'h00);
    tick();
    chk("t6_pc01", 32'(pc), 32'h01);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h30;
    stall          = 1'b1;
    tick();
    chk("t6_rs_valid", 32'(if_valid),  32'h0);
    chk("t6_rs_addr",  32'(imem_addr), 32'h30);
    redirect_valid = 1'b0;
    stall          = 1'b0;
    push_exp(8'h30);
    tick();
    chk("t6_gap_valid", 32'(if_valid), 32'h0);
    tick();
    chk("t6_tgt_valid", 32'(if_valid), 32'h1);
    chk("t6_tgt_pc",    32'(pc),       32'h30);
    tick();
    chk("t6_pc31", 32'(pc), 32'h31);
    stall = 1'b1;
    tick();
    chk("t6_stall_pc31", 32'(pc), 32'h31);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("rst2");
    chk("rst2_addr", 32'(imem_addr), 32'h00);
    chk("t6_drained", 32'(sb.size()), 32'd0);
    tick();
    tick();
    rst   = 1'b0;
    stall = 1'b0;
    push_exp(8'h00);
    push_exp(8'h01);
    tick();
    chk("t6_post_rst_valid", 32'(if_valid), 32'h0);
    tick();
    chk("t6_post_rst_pc",    32'(pc),    32'h00);
    chk("t6_post_rst_instr", 32'(instr), 32'h1000);
    tick();
    chk("t6_post_rst_pc01", 32'(pc), 32'h01);
    @(negedge clk);
    #1;
    chk("tC_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_instr_fetch_unit
`default_nettype wire
